ahb_regbank_irq: RTL and testbench

Parametrised AHB-Lite slave register bank for the Cortex-M1 AHB1 expansion window (0x60000000). It provides NUM_REGS general read/write registers with byte-lane writes, a configurable wait-state count and an interrupt controller block. The controller has edge-detected sources, a W1C status register, a mask register and a software-set register, and drives EXTINT lines. It replaces ad-hoc test register slaves and sits on the same AHB1 bus signals as the USB device slave.

---
 rtl/ahb_regbank_irq.sv | 167 ++++++++++++++++
 tb/tb_ahb_regbank_irq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_regbank_irq.sv
// ahb_regbank_irq: AHB-Lite slave with general RW registers,
// configurable wait states and an edge-triggered interrupt block.
module ahb_regbank_irq #(
  parameter int NUM_REGS    = 16,
  parameter int NUM_IRQ     = 4,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 12
) (
  input  logic                     hclk,
  input  logic                     reset,
  input  logic                     hsels,
  input  logic [31:0]              haddrs,
  input  logic [1:0]               htranss,
  input  logic [2:0]               hsizes,
  input  logic                     hwrites,
  input  logic                     hreadys,
  input  logic [31:0]              hwdatas,
  output logic                     hreadyouts,
  output logic                     hresps,
  output logic [31:0]              hrdatas,
  input  logic [NUM_IRQ-1:0]       irq_src,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_IRQ-1:0]       intr
);

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] IDX_STAT = IW'(NUM_REGS);
  localparam logic [IW-1:0] IDX_MASK = IW'(NUM_REGS + 1);
  localparam logic [IW-1:0] IDX_SET  = IW'(NUM_REGS + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] dp_idx;
  logic          dp_wr;
  logic [3:0]    dp_lanes;

  logic [31:0]        regs [NUM_REGS];
  logic [NUM_IRQ-1:0] status, mask, src_q;

  logic          accept, a_err;
  logic [IW-1:0] a_idx;
  logic [3:0]    a_lanes;
  logic          commit, wr_en;
  logic [31:0]   wmask, rd_word;
  logic [NUM_IRQ-1:0] irq_wd, w1c, set_wr, rise;
  logic          unused_ok;

  assign unused_ok = ^{haddrs[31:ADDR_W], htranss[0]};

  assign accept = hsels & hreadys & htranss[1];
  assign a_idx  = haddrs[ADDR_W-1:2];

  // Address-phase decode: byte lanes and error classification
  always_comb begin
    a_lanes = 4'b0000;
    case (hsizes)
      3'd0:    a_lanes = 4'b0001 << haddrs[1:0];
      3'd1:    a_lanes = haddrs[1] ? 4'b1100 : 4'b0011;
      3'd2:    a_lanes = 4'b1111;
      default: a_lanes = 4'b0000;
    endcase
    a_err = (a_idx > IDX_SET)
          | (hsizes > 3'd2)
          | ((hsizes == 3'd1) & haddrs[0])
          | ((hsizes == 3'd2) & (|haddrs[1:0]));
  end

  assign commit = (state == S_DATA) & hreadyouts;
  assign wr_en  = commit & dp_wr;
  assign wmask  = {{8{dp_lanes[3]}}, {8{dp_lanes[2]}},
                   {8{dp_lanes[1]}}, {8{dp_lanes[0]}}};
  assign irq_wd = hwdatas[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0];
  assign w1c    = (wr_en && dp_idx == IDX_STAT) ? irq_wd : '0;
  assign set_wr = (wr_en && dp_idx == IDX_SET) ? irq_wd : '0;
  assign rise   = irq_src & ~src_q;

  // Bus sequencing: acceptance, wait countdown, two-cycle error
  always_ff @(posedge hclk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hreadyouts <= 1'b1;
      hresps     <= 1'b0;
      dp_idx     <= '0;
      dp_wr      <= 1'b0;
      dp_lanes   <= '0;
    end else if (!hreadyouts) begin
      if (state == S_ERR1) begin
        state      <= S_ERR2;
        hreadyouts <= 1'b1;
      end else begin
        cnt        <= cnt - 4'd1;
        hreadyouts <= (cnt == 4'd1);
      end
    end else if (accept) begin
      dp_idx   <= a_idx;
      dp_wr    <= hwrites;
      dp_lanes <= a_lanes;
      if (a_err) begin
        state      <= S_ERR1;
        hreadyouts <= 1'b0;
        hresps     <= 1'b1;
      end else begin
        state      <= S_DATA;
        cnt        <= 4'(WAIT_STATES);
        hreadyouts <= (WAIT_STATES == 0);
        hresps     <= 1'b0;
      end
    end else begin
      state  <= S_IDLE;
      hresps <= 1'b0;
    end
  end

  // General registers: byte-lane merge on the final data-phase cycle
  always_ff @(posedge hclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (dp_idx == IW'(i))
          regs[i] <= (regs[i] & ~wmask) | (hwdatas & wmask);
    end
  end

  // Interrupt block: edge detect, W1C/set status, mask, output
  always_ff @(posedge hclk) begin
    if (reset) begin
      src_q  <= '0;
      status <= '0;
      mask   <= '0;
      intr   <= '0;
    end else begin
      src_q  <= irq_src;
      status <= (status & ~w1c) | rise | set_wr;
      if (wr_en && dp_idx == IDX_MASK)
        mask <= (mask & ~wmask[NUM_IRQ-1:0]) | irq_wd;
      intr   <= status & mask;
    end
  end

  // Read mux for the data-phase register
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (dp_idx == IW'(i)) rd_word = regs[i];
    unique case (1'b1)
      (dp_idx == IDX_STAT): rd_word = 32'(status);
      (dp_idx == IDX_MASK): rd_word = 32'(mask);
      default: ;
    endcase
  end

  assign hrdatas = (commit & ~dp_wr) ? rd_word : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_ahb_regbank_irq.sv
// tb_ahb_regbank_irq: random and directed bus traffic against a
// transaction-level model, run on WAIT_STATES=0 and =3 instances.
module tb_ahb_regbank_irq;

  localparam int NR = 16;
  localparam int NI = 4;
  localparam int AW = 12;

  logic hclk = 1'b0;
  logic reset = 1'b1;
  logic hsels, hwrites, hreadys;
  logic [31:0] haddrs, hwdatas;
  logic [1:0] htranss;
  logic [2:0] hsizes;
  logic [NI-1:0] irq_src;

  logic r0, r3, e0, e3;
  logic [31:0] d0, d3;
  logic [NR*32-1:0] g0, g3;
  logic [NI-1:0] i0, i3;

  bit sel;
  int ws;
  logic hs0, hs3;
  assign hs0 = hsels & ~sel;
  assign hs3 = hsels & sel;
  assign hreadys = sel ? r3 : r0;

  logic o_rdy, o_resp;
  logic [31:0] o_rd;
  logic [NI-1:0] o_intr;
  logic [NR*32-1:0] o_regs;
  assign o_rdy  = sel ? r3 : r0;
  assign o_resp = sel ? e3 : e0;
  assign o_rd   = sel ? d3 : d0;
  assign o_intr = sel ? i3 : i0;
  assign o_regs = sel ? g3 : g0;

  ahb_regbank_irq #(.NUM_REGS(NR), .NUM_IRQ(NI), .WAIT_STATES(0), .ADDR_W(AW)) u_ws0 (
    .hclk(hclk), .reset(reset), .hsels(hs0), .haddrs(haddrs),
    .htranss(htranss), .hsizes(hsizes), .hwrites(hwrites),
    .hreadys(hreadys), .hwdatas(hwdatas), .hreadyouts(r0),
    .hresps(e0), .hrdatas(d0), .irq_src(irq_src), .reg_out(g0),
    .intr(i0));

  ahb_regbank_irq #(.NUM_REGS(NR), .NUM_IRQ(NI), .WAIT_STATES(3), .ADDR_W(AW)) u_ws3 (
    .hclk(hclk), .reset(reset), .hsels(hs3), .haddrs(haddrs),
    .htranss(htranss), .hsizes(hsizes), .hwrites(hwrites),
    .hreadys(hreadys), .hwdatas(hwdatas), .hreadyouts(r3),
    .hresps(e3), .hrdatas(d3), .irq_src(irq_src), .reg_out(g3),
    .intr(i3));

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s ws=%0d t=%0t: got %h want %h",
               tag, ws, $time, got, exp);
    end
  endtask

  // reference model state
  logic [31:0]   m_reg [NR];
  logic [NI-1:0] m_st, m_mk, m_intr, m_prev;

  typedef struct {
    logic [31:0]   addr;
    logic [2:0]    size;
    logic          wr;
    logic [31:0]   wd;
    logic [1:0]    trans;
    logic [NI-1:0] irq;
  } xfer_t;

  xfer_t q[$];
  logic [NI-1:0] cur_irq;
  bit irq_rand;

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[AW-1:2]);
  endfunction

  function automatic bit f_err(input logic [31:0] a, input logic [2:0] s);
    int idx = idx_of(a);
    if (idx > NR + 2) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && a[0]) return 1'b1;
    if (s == 3'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    if (idx < NR) return m_reg[idx];
    if (idx == NR) return 32'(m_st);
    if (idx == NR + 1) return 32'(m_mk);
    return 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd,
                             output logic [NI-1:0] w1c,
                             output logic [NI-1:0] setv);
    logic [31:0] bm = '0;
    int idx = idx_of(a);
    for (int b = 0; b < 4; b++) begin
      bit on;
      if (s == 3'd0) on = (b == int'(a[1:0]));
      else if (s == 3'd1) on = ((b / 2) == int'(a[1]));
      else on = 1'b1;
      if (on) bm[8*b +: 8] = 8'hFF;
    end
    w1c = '0;
    setv = '0;
    if (idx < NR) m_reg[idx] = (m_reg[idx] & ~bm) | (wd & bm);
    else if (idx == NR) w1c = NI'(wd & bm);
    else if (idx == NR + 1) m_mk = (m_mk & ~NI'(bm)) | NI'(wd & bm);
    else if (idx == NR + 2) setv = NI'(wd & bm);
  endtask

  task automatic push(input logic [31:0] a, input logic [2:0] s,
                      input logic w, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.size = s; x.wr = w; x.wd = d;
    x.trans = 2'b10; x.irq = cur_irq;
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    xfer_t x;
    x.addr = 32'd0; x.size = 3'd0; x.wr = 1'b0; x.wd = 32'd0;
    x.trans = 2'b00; x.irq = cur_irq;
    for (int i = 0; i < n; i++) q.push_back(x);
  endtask

  // One bus cycle per iteration: drive, check at negedge, model at posedge
  task automatic run_q();
    xfer_t a, d;
    bit a_v, have, d_err, fin;
    int d_cyc;
    logic e_rdy, e_resp;
    logic [31:0] e_rd;
    logic [NI-1:0] w1c, setv, nxt_i;
    have = 1'b0; d_err = 1'b0; d_cyc = 0;
    while (q.size() > 0 || have) begin
      a_v = q.size() > 0;
      if (a_v) begin
        a = q[0];
        if (!irq_rand) irq_src = a.irq;
      end
      if (irq_rand && $urandom_range(3) == 0) irq_src = NI'($urandom);
      hsels   = 1'b1;
      haddrs  = a_v ? a.addr : $urandom;
      hsizes  = a_v ? a.size : 3'($urandom);
      hwrites = a_v ? a.wr : 1'($urandom);
      htranss = a_v ? a.trans : 2'b00;
      hwdatas = (have && d.wr) ? d.wd : $urandom;
      e_rdy = 1'b1; e_resp = 1'b0; e_rd = '0;
      if (have) begin
        if (d_err) begin
          e_rdy = (d_cyc != 0);
          e_resp = 1'b1;
        end else begin
          e_rdy = (d_cyc >= ws);
          if (e_rdy && !d.wr) e_rd = m_read(idx_of(d.addr));
        end
      end
      @(negedge hclk);
      chk("hreadyouts", 32'(o_rdy), 32'(e_rdy));
      chk("hresps", 32'(o_resp), 32'(e_resp));
      chk("hrdatas", o_rd, e_rd);
      chk("intr", 32'(o_intr), 32'(m_intr));
      fin = e_rdy;
      @(posedge hclk);
      w1c = '0; setv = '0;
      nxt_i = m_st & m_mk;
      if (have && !d_err && fin && d.wr)
        model_write(d.addr, d.size, d.wd, w1c, setv);
      m_st = (m_st & ~w1c) | (irq_src & ~m_prev) | setv;
      m_prev = irq_src;
      m_intr = nxt_i;
      if (have) begin
        if (fin) have = 1'b0;
        else d_cyc++;
      end
      if (fin && a_v) begin
        void'(q.pop_front());
        if (a.trans[1]) begin
          have = 1'b1; d = a; d_cyc = 0;
          d_err = f_err(a.addr, a.size);
        end
      end
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; hsels = 1'b0; htranss = 2'b00; irq_src = '0;
    cur_irq = '0;
    repeat (2) @(posedge hclk);
    #1 reset = 1'b0;
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_st = '0; m_mk = '0; m_intr = '0; m_prev = '0;
    @(negedge hclk);
    chk("rst_hreadyouts", 32'(o_rdy), 32'd1);
    chk("rst_hresps", 32'(o_resp), 32'd0);
    chk("rst_hrdatas", o_rd, 32'd0);
    chk("rst_intr", 32'(o_intr), 32'd0);
    chk("rst_reg_out", 32'(|o_regs), 32'd0);
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hsels = 1'b0; haddrs = '0; htranss = '0; hsizes = '0;
    hwrites = 1'b0; hwdatas = '0; irq_src = '0;
    cur_irq = '0; irq_rand = 1'b0;
    for (int r = 0; r < 2; r++) begin
      sel = (r == 1);
      ws = (r == 1) ? 3 : 0;
      do_reset();
      // word write then immediate read, read-after-write
      push(32'h04, 3'd2, 1'b1, 32'hDEADBEEF);
      push(32'h04, 3'd2, 1'b0, 32'h0);
      run_q();
      chk("reg1_word", o_regs[63:32], 32'hDEADBEEF);
      // byte and half lane writes
      push(32'h04, 3'd2, 1'b1, 32'h11223344);
      push(32'h06, 3'd0, 1'b1, 32'hFFAAFFFF);
      push(32'h02, 3'd1, 1'b1, 32'h5566ABCD);
      push(32'h04, 3'd2, 1'b0, 32'h0);
      push(32'h00, 3'd2, 1'b0, 32'h0);
      run_q();
      chk("reg1_byte", o_regs[63:32], 32'h11AA3344);
      chk("reg0_half", o_regs[31:0], 32'h55660000);
      // error responses, registers must not change
      push(32'h4C, 3'd2, 1'b0, 32'h0);
      push(32'h01, 3'd2, 1'b1, 32'hFFFFFFFF);
      push(32'h03, 3'd1, 1'b1, 32'hFFFFFFFF);
      push(32'h08, 3'd3, 1'b1, 32'hFFFFFFFF);
      push(32'hFFC, 3'd2, 1'b1, 32'hFFFFFFFF);
      push(32'h00, 3'd2, 1'b0, 32'h0);
      run_q();
      chk("reg0_after_err", o_regs[31:0], 32'h55660000);
      // interrupt pulse, clear while held high, no re-trigger
      push(32'h44, 3'd2, 1'b1, 32'h1);
      run_q();
      cur_irq = 4'h1;
      idle(5);
      push(32'h40, 3'd2, 1'b0, 32'h0);
      push(32'h40, 3'd2, 1'b1, 32'h1);
      idle(4);
      push(32'h40, 3'd2, 1'b0, 32'h0);
      run_q();
      chk("intr_cleared", 32'(o_intr), 32'd0);
      cur_irq = 4'h0;
      // set bit 2, then W1C coinciding with a rising edge
      push(32'h44, 3'd2, 1'b1, 32'hF);
      push(32'h48, 3'd2, 1'b1, 32'h4);
      push(32'h48, 3'd2, 1'b0, 32'h0);
      push(32'h40, 3'd2, 1'b1, 32'h4);
      cur_irq = 4'h4;
      idle(3);
      push(32'h40, 3'd2, 1'b0, 32'h0);
      run_q();
      cur_irq = 4'h0;
      idle(2);
      run_q();
      // random traffic
      irq_rand = 1'b1;
      for (int k = 0; k < 250; k++) begin
        xfer_t x;
        int idx = (k % 37 == 0) ? $urandom_range(1023) : $urandom_range(NR + 4);
        x.addr = {20'd0, 10'(idx), 2'($urandom_range(3))};
        if ($urandom_range(3) != 0) x.addr[1:0] = 2'd0;
        x.size = 3'($urandom_range(3));
        if ($urandom_range(3) != 0 && x.size == 3'd3) x.size = 3'd2;
        x.wr = 1'($urandom);
        x.wd = $urandom;
        x.trans = 2'($urandom);
        if ($urandom_range(2) != 0) x.trans[1] = 1'b1;
        x.irq = '0;
        q.push_back(x);
      end
      run_q();
      irq_rand = 1'b0;
      for (int i = 0; i < NR; i++)
        chk("reg_out", o_regs[32*i +: 32], m_reg[i]);
    end
    // reset asserted on the final cycle of a waited write
    sel = 1'b1; ws = 3;
    do_reset();
    hsels = 1'b1; haddrs = 32'h14; hsizes = 3'd2;
    hwrites = 1'b1; htranss = 2'b10;
    @(posedge hclk); #1;
    htranss = 2'b00; hwdatas = 32'hCAFEF00D;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("ws3_final_ready", 32'(o_rdy), 32'd1);
    reset = 1'b1;
    @(posedge hclk); #1 reset = 1'b0;
    @(negedge hclk);
    chk("abort_ready", 32'(o_rdy), 32'd1);
    chk("abort_resp", 32'(o_resp), 32'd0);
    chk("abort_reg5", o_regs[32*5 +: 32], 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("abort_reg5_late", o_regs[32*5 +: 32], 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
